// File: rtl/ff256_ct_seq_arbiter_pkg.sv
// Shared types and constants for the FF(256) cosine-transform engine arbiter.
package ff256_ct_seq_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_LOAD  = 3'd1,
    ARB_RUN   = 3'd2,
    ARB_RESP  = 3'd3,
    ARB_DRAIN = 3'd4
  } arb_state_t;

  localparam int ARB_WDOG_W = 8;
  localparam int ARB_DATA_W = 64;

  // Round-robin successor of idx for n requesters, wrapping to 0.
  function automatic int rr_wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/ff256_ct_seq_arbiter_rr.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
module ff256_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  // Scan requesters in priority order starting from the pointer.
  always_comb begin
    logic [ID_W-1:0] k;
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    k         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_vld && req_valid[k]) begin
        grant_vld   = 1'b1;
        grant_oh[k] = 1'b1;
        grant_idx   = k;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

endmodule

// File: rtl/ff256_ct_seq_arbiter.sv
// Shares one sequential FF(256) cosine-transform engine between NUM_REQ requesters,
// with round-robin grant, result tagging and a RUN-state watchdog.
module ff256_ct_seq_arbiter
  import ff256_ct_seq_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*64-1:0]   req_x,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [ARB_DATA_W-1:0]   rsp_x,
  output logic                    rsp_err,
  output logic [ARB_DATA_W-1:0]   eng_x_in,
  output logic                    eng_start,
  input  logic                    eng_done,
  input  logic [ARB_DATA_W-1:0]   eng_x_out,
  output logic                    busy
);

  localparam logic [ARB_WDOG_W-1:0] WDOG_LAST = ARB_WDOG_W'(TIMEOUT - 1);

  arb_state_t                state_q, state_d;
  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [ARB_WDOG_W-1:0]     wdog_q, wdog_d;
  logic [ARB_DATA_W-1:0]     eng_x_q, eng_x_d;
  logic [ID_W-1:0]           id_q, id_d;
  logic [ARB_DATA_W-1:0]     rsp_x_q, rsp_x_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
  logic                      eng_start_q, eng_start_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      busy_q, busy_d;

  logic [NUM_REQ-1:0]        grant_oh;
  logic [ID_W-1:0]           grant_idx;
  logic                      grant_vld;
  logic [ARB_DATA_W-1:0]     req_x_s [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_x_s[gi] = req_x[64*gi +: 64];
  end

  ff256_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; grants are only considered in IDLE, so a pending result stalls everyone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (grant_vld) state_d = ARB_LOAD; else state_d = ARB_IDLE;
      ARB_LOAD:  state_d = ARB_RUN;
      ARB_RUN:   if (eng_done || (wdog_q == WDOG_LAST)) state_d = ARB_RESP; else state_d = ARB_RUN;
      ARB_RESP:  if (rsp_ready) state_d = ARB_DRAIN; else state_d = ARB_RESP;
      ARB_DRAIN: if (!eng_done) state_d = ARB_IDLE; else state_d = ARB_DRAIN;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are decoded from state_d so they line up with state_q.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    eng_x_d     = eng_x_q;
    id_d        = id_q;
    rsp_x_d     = rsp_x_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_vld) begin
          eng_x_d     = req_x_s[grant_idx];
          id_d        = grant_idx;
          rr_ptr_d    = ID_W'(rr_wrap_inc(int'(grant_idx), NUM_REQ));
          req_ready_d = grant_oh;
        end else begin
          req_ready_d = '0;
        end
      end
      ARB_LOAD: wdog_d = '0;
      ARB_RUN: begin
        wdog_d = wdog_q + ARB_WDOG_W'(1);
        // Done takes priority over a watchdog expiry in the same cycle.
        if (eng_done) begin
          rsp_x_d   = eng_x_out;
          rsp_err_d = 1'b0;
        end else if (wdog_q == WDOG_LAST) begin
          rsp_x_d   = '0;
          rsp_err_d = 1'b1;
        end else begin
          rsp_err_d = rsp_err_q;
        end
      end
      default: wdog_d = wdog_q;
    endcase
    eng_start_d = (state_d == ARB_RUN);
    rsp_valid_d = (state_d == ARB_RESP);
    busy_d      = (state_d != ARB_IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      eng_x_q     <= '0;
      id_q        <= '0;
      rsp_x_q     <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      eng_x_q     <= eng_x_d;
      id_q        <= id_d;
      rsp_x_q     <= rsp_x_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_err   = rsp_err_q;
  assign eng_x_in  = eng_x_q;
  assign eng_start = eng_start_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ff256_ct_seq_arbiter.sv
// Directed table-driven bench for ff256_ct_seq_arbiter with a behavioural engine model.
module tb_ff256_ct_seq_arbiter;

  localparam logic [63:0] X1  = 64'h1111111111111111;
  localparam logic [63:0] X2  = 64'h2222222222222222;
  localparam logic [63:0] X3  = 64'h3333333333333333;
  localparam logic [63:0] X4  = 64'h4444444444444444;
  localparam logic [63:0] NX1 = 64'hEEEEEEEEEEEEEEEE;
  localparam logic [63:0] NX2 = 64'hDDDDDDDDDDDDDDDD;
  localparam logic [63:0] NX3 = 64'hCCCCCCCCCCCCCCCC;
  localparam logic [63:0] NX4 = 64'hBBBBBBBBBBBBBBBB;
  localparam logic [63:0] XS  = 64'h0102030405060708;
  localparam logic [63:0] XA5 = 64'hA5A5A5A5A5A5A5A5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = 4'h0;
  logic [255:0] req_x = {X4, X3, X2, X1};
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_x;
  logic         rsp_err;
  logic [63:0]  eng_x_in;
  logic         eng_start;
  logic         eng_done;
  logic [63:0]  eng_x_out;
  logic         busy;

  int  eng_lat   = 1;
  bit  eng_never = 1'b0;
  bit  eng_fixed = 1'b0;
  int  eng_cnt;
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  typedef struct {
    logic [3:0]  mask;
    int          lat;
    bit          never;
    int          hold;
    int          exp_id;
    logic [63:0] exp_in;
    logic [63:0] exp_x;
    bit          exp_err;
    int          exp_run;
  } vec_t;

  vec_t vecs [16];

  ff256_ct_seq_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_err(rsp_err), .eng_x_in(eng_x_in),
    .eng_start(eng_start), .eng_done(eng_done), .eng_x_out(eng_x_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Engine model: DONE is visible eng_lat cycles after start is first seen; drops once start falls.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (!eng_start) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (!eng_never && !eng_done) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt + 1 >= eng_lat) eng_done <= 1'b1;
    end
  end
  assign eng_x_out = eng_done ? (eng_fixed ? XA5 : ~eng_x_in) : 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic run_job(input string tag, input logic [3:0] mask, input int lat, input bit never,
                         input int hold, input int exp_id, input logic [63:0] exp_in,
                         input logic [63:0] exp_x, input bit exp_err, input int exp_run,
                         output int lat_cyc);
    int n;
    int run;
    int bad;
    logic [3:0] exp_oh;
    exp_oh    = 4'b0001 << exp_id;
    eng_lat   = lat;
    eng_never = never;
    lat_cyc   = 0;
    req_valid = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 4'h0 && n < 20);
    chk({tag, " grant_seen"}, 64'(req_ready != 4'h0), 64'd1);
    if (req_ready == 4'h0) begin
      req_valid = 4'h0;
      return;
    end
    chk({tag, " req_ready"}, 64'(req_ready), 64'(exp_oh));
    chk({tag, " eng_x_in"}, eng_x_in, exp_in);
    req_valid = req_valid & ~req_ready;
    run = 0;
    do begin
      @(negedge clk);
      lat_cyc++;
      if (eng_start) run++;
    end while (!rsp_valid && lat_cyc < 300);
    chk({tag, " rsp_valid_seen"}, 64'(rsp_valid), 64'd1);
    chk({tag, " run_cycles"}, 64'(run), 64'(exp_run));
    chk({tag, " rsp_id"}, 64'(rsp_id), 64'(exp_id));
    chk({tag, " rsp_x"}, rsp_x, exp_x);
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_x == exp_x && rsp_id == 2'(exp_id) && rsp_err == exp_err &&
            req_ready == 4'h0 && !eng_start)) bad++;
    end
    if (hold > 0) chk({tag, " backpressure_bad_cycles"}, 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    req_valid = 4'h0;
    @(negedge clk);
    rsp_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 10);
    chk({tag, " back_to_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lc;
    vecs[0]  = '{4'hF, 1,  1'b0, 0,  0, X1, NX1,   1'b0, 2};
    vecs[1]  = '{4'hF, 10, 1'b0, 0,  1, X2, NX2,   1'b0, 11};
    vecs[2]  = '{4'hF, 3,  1'b0, 0,  2, X3, NX3,   1'b0, 4};
    vecs[3]  = '{4'hF, 1,  1'b0, 0,  3, X4, NX4,   1'b0, 2};
    vecs[4]  = '{4'hF, 5,  1'b0, 0,  0, X1, NX1,   1'b0, 6};
    vecs[5]  = '{4'hF, 2,  1'b0, 20, 1, X2, NX2,   1'b0, 3};
    vecs[6]  = '{4'hF, 1,  1'b0, 0,  2, X3, NX3,   1'b0, 2};
    vecs[7]  = '{4'hF, 4,  1'b0, 0,  3, X4, NX4,   1'b0, 5};
    vecs[8]  = '{4'h4, 2,  1'b0, 0,  2, X3, NX3,   1'b0, 3};
    vecs[9]  = '{4'h3, 1,  1'b0, 0,  0, X1, NX1,   1'b0, 2};
    vecs[10] = '{4'h3, 1,  1'b0, 0,  1, X2, NX2,   1'b0, 2};
    vecs[11] = '{4'h8, 1,  1'b0, 0,  3, X4, NX4,   1'b0, 2};
    vecs[12] = '{4'h8, 2,  1'b0, 0,  3, X4, NX4,   1'b0, 3};
    vecs[13] = '{4'h1, 0,  1'b1, 0,  0, X1, 64'h0, 1'b1, 64};
    vecs[14] = '{4'h2, 63, 1'b0, 0,  1, X2, NX2,   1'b0, 64};
    vecs[15] = '{4'h1, 64, 1'b0, 0,  0, X1, 64'h0, 1'b1, 64};

    #1 reset = 1'b0;
    #2;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset eng_start", 64'(eng_start), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_fields", {rsp_x[61:0], rsp_id}, 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    chk("reset eng_x_in", eng_x_in, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      run_job($sformatf("vec%0d", v), vecs[v].mask, vecs[v].lat, vecs[v].never, vecs[v].hold,
              vecs[v].exp_id, vecs[v].exp_in, vecs[v].exp_x, vecs[v].exp_err, vecs[v].exp_run, lc);
    end

    req_x[63:0] = XS;
    eng_fixed   = 1'b1;
    run_job("single", 4'h1, 10, 1'b0, 0, 0, XS, XA5, 1'b0, 11, lc);
    chk("single grant_to_rsp_cycles", 64'(lc), 64'd12);

    eng_lat   = 30;
    eng_never = 1'b0;
    req_valid = 4'h4;
    lc = 0;
    do begin @(negedge clk); lc++; end while (!eng_start && lc < 20);
    req_valid = 4'h0;
    repeat (3) @(negedge clk);
    chk("arst pre eng_start", 64'(eng_start), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst eng_start", 64'(eng_start), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job("after_arst", 4'hF, 2, 1'b0, 0, 0, XS, XA5, 1'b0, 3, lc);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
